bb8051_sfr_master: RTL and testbench
====================================

BB8051_SFR_MASTER -- requirements
Module: bb8051_sfr_master

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low: clk is the clock, rst_n is the reset.
REQ-002 SHALL have parameter SFR_BASE, default 8'h80: lowest legal direct SFR address.
REQ-003 Port list:
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 req_valid  in  1  core request strobe
 req_ready  out  1  block idle, can accept a request
 req_op  in  3  000 RD_BYTE, 001 WR_BYTE, 010 RD_BIT, 011 WR_BIT, 100 CPL_BIT, 101 ANL, 110 ORL, 111 XRL
 req_addr  in  8  direct byte address, or bit address for bit ops
 req_data  in  8  write/mask operand; for WR_BIT, bit value is req_data[0]
 rsp_valid  out  1  one-cycle response pulse
 rsp_data  out  8  byte read, or post-write byte value
 rsp_bit  out  1  bit read result
 rsp_err  out  1  request rejected, no SFR access made
 sfr_addr  out  8  SFR byte address
 sfr_action  out  2  00 IDLE, 01 RD_BYTE, 10 WR_BYTE, 11 WR_BIT
 bit_addr  out  3  bit index for WR_BIT
 bit_data  out  1  bit value for WR_BIT
 wr_data  out  8  byte write data
 rd_data  in  8  SFR read data, valid in the cycle after a RD_BYTE action

Function
REQ-004 SHALL drive req_ready=1 only in state IDLE; accept when req_valid&req_ready, latching op, address and data.
REQ-005 States: IDLE, RD, CAP, WR, RESP; sfr_action SHALL be non-IDLE only in RD (RD_BYTE) and WR (WR_BYTE/WR_BIT).
REQ-006 Bit ops SHALL map bit address b to sfr_addr={b[7:3],3'b000} and bit_addr=b[2:0].
REQ-007 For an accept in cycle N, WR_BYTE/WR_BIT SHALL issue WR in N+1 and RESP in N+2.
REQ-008 RD_BYTE/RD_BIT SHALL issue RD in N+1, capture rd_data in CAP (N+2), and RESP in N+3.
REQ-009 In RESP, RD_BIT SHALL set rsp_bit to captured byte[bit_addr].
REQ-010 CPL_BIT SHALL run RD (N+1), CAP (N+2), WR_BIT with bit_data=~captured[bit] (N+3), and RESP (N+4).
REQ-011 ANL/ORL/XRL SHALL follow the same RD/CAP/WR sequence; wr_data = captured AND/OR/XOR req_data, written as WR_BYTE.
REQ-012 For write-type ops, rsp_data SHALL equal the byte value after the write, and unaffected response bits SHALL be 0.
REQ-013 A request with req_addr<SFR_BASE (byte ops) or req_addr[7]=0 (bit ops) SHALL go IDLE->RESP with rsp_err=1 and no SFR action.
REQ-014 rsp_valid SHALL be high for exactly the one RESP cycle, with no backpressure; RESP SHALL always return to IDLE.
REQ-015 sfr_addr, wr_data, bit_addr and bit_data SHALL hold their last values when the action is IDLE.
REQ-016 req_valid while req_ready=0 SHALL be ignored.

Reset
REQ-017 Asserting rst_n low SHALL immediately force state=IDLE, sfr_action=00, and all other outputs 0 except req_ready, even mid-operation.
REQ-018 After deassertion, req_ready SHALL be 1 and no response SHALL be emitted for an aborted request.

Configuration
REQ-019 With BB8051_SFR_RMW_EN defined, ANL/ORL/XRL SHALL be supported per REQ-011.
REQ-020 Without BB8051_SFR_RMW_EN, ANL/ORL/XRL SHALL respond as in REQ-013 (rsp_err=1, no access), and the RMW datapath SHALL be omitted.

Verification
REQ-021 WR_BYTE addr 0xE0 data 0x5A -> N+1 action=10 addr=0xE0 wr_data=0x5A; N+2 rsp_valid, rsp_data=0x5A.
REQ-022 RD_BIT addr 0xE3, SFR 0xE0 returns 0x08 -> N+1 action=01 addr=0xE0; N+3 rsp_bit=1.
REQ-023 CPL_BIT addr 0xD7, SFR 0xD0=0x80 -> N+3 action=11 bit_addr=7 bit_data=0; N+4 rsp_data=0x00.
REQ-024 ORL addr 0xA8 data 0x0F, SFR=0x30 -> with macro: N+3 wr_data=0x3F; without macro: N+1 rsp_err=1, no action.
REQ-025 WR_BIT addr 0x25 -> N+1 rsp_err=1, sfr_action stays 00.
REQ-026 rst_n low in the CAP cycle of a CPL_BIT -> no WR action and no rsp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/bb8051_sfr_master.sv
// -----------------------------------------------------------------------------
// bb8051_sfr_master
// Sequences core SFR requests into single-cycle SFR bus actions: byte and bit
// reads/writes, complement-bit, and (optionally) ANL/ORL/XRL read-modify-write.
// Each request produces exactly one rsp_valid pulse.
//
// Optional feature: define BB8051_SFR_RMW_EN to enable ANL/ORL/XRL. Without it
// those opcodes are rejected with rsp_err and the RMW datapath is not built.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake (ready only when idle)
//   req_op/addr/data        opcode, direct byte or bit address, operand
//   rsp_valid/data/bit/err  one-cycle response pulse and its payload
//   sfr_addr/sfr_action     SFR bus address and action (IDLE/RD/WR/WR_BIT)
//   bit_addr/bit_data       bit index and value for bit writes
//   wr_data                 byte write data
//   rd_data                 SFR read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module bb8051_sfr_master #(
    parameter logic [7:0] SFR_BASE = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_bit,
    output logic       rsp_err,
    output logic [7:0] sfr_addr,
    output logic [1:0] sfr_action,
    output logic [2:0] bit_addr,
    output logic       bit_data,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data
);

    localparam int unsigned DW = 8;

    localparam logic [2:0] OP_RD_BYTE = 3'b000;
    localparam logic [2:0] OP_WR_BYTE = 3'b001;
    localparam logic [2:0] OP_RD_BIT  = 3'b010;
    localparam logic [2:0] OP_WR_BIT  = 3'b011;
    localparam logic [2:0] OP_CPL_BIT = 3'b100;
    localparam logic [2:0] OP_ANL     = 3'b101;
    localparam logic [2:0] OP_ORL     = 3'b110;
    localparam logic [2:0] OP_XRL     = 3'b111;

    localparam logic [1:0] ACT_IDLE    = 2'b00;
    localparam logic [1:0] ACT_RD_BYTE = 2'b01;
    localparam logic [1:0] ACT_WR_BYTE = 2'b10;
    localparam logic [1:0] ACT_WR_BIT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2:0]      r_op;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   r_cap;

    logic            r_req_ready;
    logic [1:0]      r_sfr_action;
    logic [DW-1:0]   r_sfr_addr;
    logic [DW-1:0]   r_wr_data;
    logic [2:0]      r_bit_addr;
    logic            r_bit_data;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_bit;
    logic            r_rsp_err;

    logic            w_req_ready_nxt;
    logic [1:0]      w_sfr_action_nxt;
    logic [DW-1:0]   w_sfr_addr_nxt;
    logic [DW-1:0]   w_wr_data_nxt;
    logic [2:0]      w_bit_addr_nxt;
    logic            w_bit_data_nxt;
    logic            w_rsp_valid_nxt;
    logic [DW-1:0]   w_rsp_data_nxt;
    logic            w_rsp_bit_nxt;
    logic            w_rsp_err_nxt;

    logic            w_accept;
    logic [2:0]      w_op;
    logic [DW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_is_bit;
    logic            w_legal;
    logic [DW-1:0]   w_byte_addr;
    logic [2:0]      w_bit_idx;
    logic [DW-1:0]   w_bit_mask;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // While idle the live request is decoded; afterwards the latched copy.
    assign w_op   = (r_state == S_IDLE) ? req_op   : r_op;
    assign w_addr = (r_state == S_IDLE) ? req_addr : r_addr;
    assign w_data = (r_state == S_IDLE) ? req_data : r_data;

    assign w_is_bit    = (w_op == OP_RD_BIT) || (w_op == OP_WR_BIT) || (w_op == OP_CPL_BIT);
    assign w_byte_addr = w_is_bit ? {w_addr[7:3], 3'b000} : w_addr;
    assign w_bit_idx   = w_addr[2:0];
    assign w_bit_mask  = DW'(1) << w_bit_idx;

`ifdef BB8051_SFR_RMW_EN
    logic [DW-1:0] w_rmw_res;

    // RMW result formed from the byte arriving in the capture cycle.
    always_comb begin
        w_rmw_res = rd_data & w_data;
        case (w_op)
            OP_ORL:  w_rmw_res = rd_data | w_data;
            OP_XRL:  w_rmw_res = rd_data ^ w_data;
            default: w_rmw_res = rd_data & w_data;
        endcase
    end

    // Bit ops need a bit-addressable byte (addr[7]); byte ops need >= SFR_BASE.
    always_comb begin
        w_legal = w_is_bit ? w_addr[7] : (w_addr >= SFR_BASE);
    end
`else
    logic w_is_rmw;

    assign w_is_rmw = (w_op == OP_ANL) || (w_op == OP_ORL) || (w_op == OP_XRL);

    // Bit ops need a bit-addressable byte (addr[7]); byte ops need >= SFR_BASE.
    always_comb begin
        w_legal = w_is_bit ? w_addr[7] : (w_addr >= SFR_BASE);
        if (w_is_rmw) begin
            w_legal = 1'b0;
        end
    end
`endif

    // State register, request latch, capture register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= 3'b000;
            r_addr       <= '0;
            r_data       <= '0;
            r_cap        <= '0;
            r_req_ready  <= 1'b1;
            r_sfr_action <= ACT_IDLE;
            r_sfr_addr   <= '0;
            r_wr_data    <= '0;
            r_bit_addr   <= '0;
            r_bit_data   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_bit    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op   <= req_op;
                r_addr <= req_addr;
                r_data <= req_data;
            end
            if (r_state == S_CAP) begin
                r_cap <= rd_data;
            end
            r_req_ready  <= w_req_ready_nxt;
            r_sfr_action <= w_sfr_action_nxt;
            r_sfr_addr   <= w_sfr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_bit_addr   <= w_bit_addr_nxt;
            r_bit_data   <= w_bit_data_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_rsp_bit    <= w_rsp_bit_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_state_nxt = S_RESP;
                    end else if ((w_op == OP_WR_BYTE) || (w_op == OP_WR_BIT)) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD:    w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = ((w_op == OP_RD_BYTE) || (w_op == OP_RD_BIT)) ? S_RESP : S_WR;
            S_WR:    w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: values for the state being entered, registered above.
    always_comb begin
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
        w_sfr_action_nxt = ACT_IDLE;
        w_sfr_addr_nxt   = r_sfr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_bit_addr_nxt   = r_bit_addr;
        w_bit_data_nxt   = r_bit_data;
        w_rsp_valid_nxt  = 1'b0;
        w_rsp_data_nxt   = '0;
        w_rsp_bit_nxt    = 1'b0;
        w_rsp_err_nxt    = 1'b0;

        case (w_state_nxt)
            S_RD: begin
                w_sfr_action_nxt = ACT_RD_BYTE;
                w_sfr_addr_nxt   = w_byte_addr;
            end
            S_WR: begin
                case (w_op)
                    OP_WR_BYTE: begin
                        w_sfr_action_nxt = ACT_WR_BYTE;
                        w_sfr_addr_nxt   = w_byte_addr;
                        w_wr_data_nxt    = w_data;
                    end
                    OP_WR_BIT: begin
                        w_sfr_action_nxt = ACT_WR_BIT;
                        w_sfr_addr_nxt   = w_byte_addr;
                        w_bit_addr_nxt   = w_bit_idx;
                        w_bit_data_nxt   = w_data[0];
                    end
                    OP_CPL_BIT: begin
                        // Entered from CAP, so rd_data is the byte being modified.
                        w_sfr_action_nxt = ACT_WR_BIT;
                        w_sfr_addr_nxt   = w_byte_addr;
                        w_bit_addr_nxt   = w_bit_idx;
                        w_bit_data_nxt   = ~rd_data[w_bit_idx];
                    end
`ifdef BB8051_SFR_RMW_EN
                    OP_ANL, OP_ORL, OP_XRL: begin
                        w_sfr_action_nxt = ACT_WR_BYTE;
                        w_sfr_addr_nxt   = w_byte_addr;
                        w_wr_data_nxt    = w_rmw_res;
                    end
`endif
                    default: begin
                        w_sfr_action_nxt = ACT_IDLE;
                    end
                endcase
            end
            S_RESP: begin
                w_rsp_valid_nxt = 1'b1;
                if (r_state == S_IDLE) begin
                    w_rsp_err_nxt = 1'b1;
                end else begin
                    case (w_op)
                        OP_RD_BYTE: w_rsp_data_nxt = rd_data;
                        OP_RD_BIT:  w_rsp_bit_nxt  = rd_data[w_bit_idx];
                        OP_WR_BYTE: w_rsp_data_nxt = r_wr_data;
                        // Only the written bit is known; the rest of the byte reads 0.
                        OP_WR_BIT:  w_rsp_data_nxt = DW'(r_bit_data) << r_bit_addr;
                        OP_CPL_BIT: w_rsp_data_nxt = r_cap ^ w_bit_mask;
`ifdef BB8051_SFR_RMW_EN
                        OP_ANL, OP_ORL, OP_XRL: w_rsp_data_nxt = r_wr_data;
`endif
                        default:    w_rsp_data_nxt = '0;
                    endcase
                end
            end
            default: begin
                w_sfr_action_nxt = ACT_IDLE;
            end
        endcase
    end

    assign req_ready  = r_req_ready;
    assign sfr_action = r_sfr_action;
    assign sfr_addr   = r_sfr_addr;
    assign wr_data    = r_wr_data;
    assign bit_addr   = r_bit_addr;
    assign bit_data   = r_bit_data;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_bit    = r_rsp_bit;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_bb8051_sfr_master.sv
// -----------------------------------------------------------------------------
// tb_bb8051_sfr_master
// Transaction-level model: each accepted request is expanded into the list of
// per-cycle output vectors it must produce; a compare process checks the DUT
// against that list every cycle (idle cycles expect held bus values). A bench
// SFR array answers reads and absorbs writes. Directed cases pin literals.
// -----------------------------------------------------------------------------
module tb_bb8051_sfr_master;

    localparam logic [7:0] BASE = 8'h80;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_bit;
    logic       rsp_err;
    logic [7:0] sfr_addr;
    logic [1:0] sfr_action;
    logic [2:0] bit_addr;
    logic       bit_data;
    logic [7:0] wr_data;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;

    bb8051_sfr_master #(.SFR_BASE(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_bit    (rsp_bit),
        .rsp_err    (rsp_err),
        .sfr_addr   (sfr_addr),
        .sfr_action (sfr_action),
        .bit_addr   (bit_addr),
        .bit_data   (bit_data),
        .wr_data    (wr_data),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: ready, action[2], addr[8], wr_data[8], bit_addr[3], bit_data,
    //                rsp_valid, rsp_data[8], rsp_bit, rsp_err
    logic [33:0] act_vec;
    assign act_vec = {req_ready, sfr_action, sfr_addr, wr_data, bit_addr, bit_data,
                      rsp_valid, rsp_data, rsp_bit, rsp_err};

    // ---------------- bench SFR space ----------------
    logic [7:0] mem [256];
    logic       mem_init;
    logic       set_en;
    logic [7:0] set_addr;
    logic [7:0] set_val;

    always @(posedge clk) begin
        rd_data <= 8'($urandom);
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
        end else if (set_en) begin
            mem[set_addr] <= set_val;
        end else begin
            case (sfr_action)
                2'b01:   rd_data <= mem[sfr_addr];
                2'b10:   mem[sfr_addr] <= wr_data;
                2'b11:   mem[sfr_addr][bit_addr] <= bit_data;
                default: ;
            endcase
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [256];
    logic [7:0]  h_addr, h_wrd;
    logic [2:0]  h_bidx;
    logic        h_bdat;
    logic [33:0] exp_q [$];
    logic [33:0] exp_now;
    logic [33:0] snap [1:6];

    function automatic logic [33:0] pk(logic rdy, logic [1:0] act, logic [7:0] a, logic [7:0] wd,
                                       logic [2:0] bi, logic bd, logic rv, logic [7:0] rdat,
                                       logic rb, logic er);
        return {rdy, act, a, wd, bi, bd, rv, rdat, rb, er};
    endfunction

    function automatic logic [33:0] hv(logic [1:0] act, logic rv, logic [7:0] rdat, logic rb, logic er);
        return pk(1'b0, act, h_addr, h_wrd, h_bidx, h_bdat, rv, rdat, rb, er);
    endfunction

    // Expand one accepted request into its expected per-cycle outputs.
    task automatic build(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
        logic       bitop, legal;
        logic [7:0] ba, v, res;
        logic [2:0] bi;
        bitop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        ba    = bitop ? {a[7:3], 3'b000} : a;
        bi    = a[2:0];
        v     = ref_mem[ba];
        legal = bitop ? a[7] : (a >= BASE);
`ifndef BB8051_SFR_RMW_EN
        if (op >= 3'd5) legal = 1'b0;
`endif
        if (!legal) begin
            exp_q.push_back(hv(2'd0, 1'b1, 8'h00, 1'b0, 1'b1));
            return;
        end
        case (op)
            3'd0: begin
                h_addr = ba;
                exp_q.push_back(hv(2'd1, 0, 0, 0, 0));
                exp_q.push_back(hv(2'd0, 0, 0, 0, 0));
                exp_q.push_back(hv(2'd0, 1, v, 0, 0));
            end
            3'd2: begin
                h_addr = ba;
                exp_q.push_back(hv(2'd1, 0, 0, 0, 0));
                exp_q.push_back(hv(2'd0, 0, 0, 0, 0));
                exp_q.push_back(hv(2'd0, 1, 8'h00, v[bi], 0));
            end
            3'd1: begin
                h_addr = ba; h_wrd = d;
                exp_q.push_back(hv(2'd2, 0, 0, 0, 0));
                ref_mem[ba] = d;
                exp_q.push_back(hv(2'd0, 1, d, 0, 0));
            end
            3'd3: begin
                h_addr = ba; h_bidx = bi; h_bdat = d[0];
                exp_q.push_back(hv(2'd3, 0, 0, 0, 0));
                ref_mem[ba][bi] = d[0];
                exp_q.push_back(hv(2'd0, 1, 8'(d[0]) << bi, 0, 0));
            end
            3'd4: begin
                h_addr = ba;
                exp_q.push_back(hv(2'd1, 0, 0, 0, 0));
                exp_q.push_back(hv(2'd0, 0, 0, 0, 0));
                h_bidx = bi; h_bdat = ~v[bi];
                exp_q.push_back(hv(2'd3, 0, 0, 0, 0));
                ref_mem[ba][bi] = ~v[bi];
                exp_q.push_back(hv(2'd0, 1, ref_mem[ba], 0, 0));
            end
            default: begin
                res = (op == 3'd5) ? (v & d) : (op == 3'd6) ? (v | d) : (v ^ d);
                h_addr = ba;
                exp_q.push_back(hv(2'd1, 0, 0, 0, 0));
                exp_q.push_back(hv(2'd0, 0, 0, 0, 0));
                h_wrd = res;
                exp_q.push_back(hv(2'd2, 0, 0, 0, 0));
                ref_mem[ba] = res;
                exp_q.push_back(hv(2'd0, 1, res, 0, 0));
            end
        endcase
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst_n)                  exp_now = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else if (exp_q.size() != 0)  exp_now = exp_q.pop_front();
        else                         exp_now = pk(1, 0, h_addr, h_wrd, h_bidx, h_bdat, 0, 0, 0, 0);
        checks++;
        if (act_vec !== exp_now) begin
            failures++;
            $display("FAIL cycle_compare t=%0t act=%h exp=%h", $time, act_vec, exp_now);
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, a, e);
        end
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [7:0] v);
        @(posedge clk); #1;
        set_en = 1'b1; set_addr = a; set_val = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        set_en = 1'b0;
    endtask

    // Issue one request from idle; snapshot outputs for each cycle of its trace.
    task automatic do_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d, input bit junk);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
        @(posedge clk);
        build(op, a, d);
        n = exp_q.size();
        #1;
        for (int k = 1; k <= n; k++) begin
            if (junk) begin
                req_valid = 1'($urandom);
                req_op    = 3'($urandom);
                req_addr  = 8'($urandom);
                req_data  = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (k <= 6) snap[k] = act_vec;
        end
        req_valid = 1'b0;
    endtask

    logic [7:0] saved;
    logic [7:0] raddr;

    initial begin
        rst_n = 1'b0; mem_init = 1'b1; set_en = 1'b0; set_addr = '0; set_val = '0;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
        h_addr = '0; h_wrd = '0; h_bidx = '0; h_bdat = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
        for (int i = 1; i <= 6; i++) snap[i] = '0;

        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_action", 32'(sfr_action), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Byte write to ACC.
        do_req(3'd1, 8'hE0, 8'h5A, 1'b0);
        chk("wrb_action", 32'(snap[1][32:31]), 32'h2);
        chk("wrb_addr",   32'(snap[1][30:23]), 32'hE0);
        chk("wrb_wdata",  32'(snap[1][22:15]), 32'h5A);
        chk("wrb_rvalid", 32'(snap[2][10]),    32'h1);
        chk("wrb_rdata",  32'(snap[2][9:2]),   32'h5A);

        // Bit read ACC.3 with ACC = 0x08.
        set_mem(8'hE0, 8'h08);
        do_req(3'd2, 8'hE3, 8'h00, 1'b1);
        chk("rdbit_action", 32'(snap[1][32:31]), 32'h1);
        chk("rdbit_addr",   32'(snap[1][30:23]), 32'hE0);
        chk("rdbit_rvalid", 32'(snap[3][10]),    32'h1);
        chk("rdbit_bit",    32'(snap[3][1]),     32'h1);

        // Complement PSW.7 with PSW = 0x80.
        set_mem(8'hD0, 8'h80);
        do_req(3'd4, 8'hD7, 8'h00, 1'b1);
        chk("cpl_action", 32'(snap[3][32:31]), 32'h3);
        chk("cpl_bidx",   32'(snap[3][14:12]), 32'h7);
        chk("cpl_bdat",   32'(snap[3][11]),    32'h0);
        chk("cpl_rvalid", 32'(snap[4][10]),    32'h1);
        chk("cpl_rdata",  32'(snap[4][9:2]),   32'h00);
        chk("cpl_mem",    32'(mem[8'hD0]),     32'h00);

        // ORL IE with 0x0F, IE = 0x30.
        set_mem(8'hA8, 8'h30);
        do_req(3'd6, 8'hA8, 8'h0F, 1'b1);
`ifdef BB8051_SFR_RMW_EN
        chk("orl_action", 32'(snap[3][32:31]), 32'h2);
        chk("orl_wdata",  32'(snap[3][22:15]), 32'h3F);
        chk("orl_rdata",  32'(snap[4][9:2]),   32'h3F);
`else
        chk("orl_err",    32'(snap[1][0]),     32'h1);
        chk("orl_rvalid", 32'(snap[1][10]),    32'h1);
        chk("orl_action", 32'(snap[1][32:31]), 32'h0);
`endif

        // Bit write to non-SFR bit address.
        do_req(3'd3, 8'h25, 8'h01, 1'b1);
        chk("wrbit_err",    32'(snap[1][0]),     32'h1);
        chk("wrbit_rvalid", 32'(snap[1][10]),    32'h1);
        chk("wrbit_action", 32'(snap[1][32:31]), 32'h0);

        // Reset during the capture cycle of a CPL_BIT.
        set_mem(8'hD0, 8'h80);
        saved = ref_mem[8'hD0];
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd4; req_addr = 8'hD7; req_data = 8'h00;
        @(posedge clk);
        build(3'd4, 8'hD7, 8'h00);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        h_addr = '0; h_wrd = '0; h_bidx = '0; h_bdat = 1'b0;
        ref_mem[8'hD0] = saved;
        #1;
        chk("abort_action", 32'(sfr_action), 32'h0);
        chk("abort_ready",  32'(req_ready),  32'h1);
        chk("abort_rvalid", 32'(rsp_valid),  32'h0);
        chk("abort_addr",   32'(sfr_addr),   32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_abort_ready", 32'(req_ready),    32'h1);
        chk("post_abort_mem",   32'(mem[8'hD0]),   32'h80);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            raddr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(128, 255)) : 8'($urandom);
            do_req(3'($urandom), raddr, 8'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
